// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches each word over a req/ack handshake and presents it to the decoder.
// Optional RETIRE_COUNT_EN adds o_retired_count, a count of instructions that retired normally.
//
// state   | meaning
// BOOT    | just out of reset, no request yet
// FETCH   | o_imem_req high, waiting for i_imem_ack
// EXEC    | instruction live, decoder/execute controls evaluated
// HALTED  | stopped until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_stall,
  input  logic        i_halt,
  input  logic        i_halt_now,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_halted,
  output logic        o_fault
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] o_retired_count
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALTED} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt, w_pc_plus4;
  logic [31:0]      r_instr;
  logic             r_fault;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_load_instr, w_set_fault, w_retire, w_cnt_load, w_timeout;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_timeout  = (ACK_TIMEOUT != 0) && (r_wait_cnt == '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load_instr = 1'b0;
    w_set_fault  = 1'b0;
    w_retire     = 1'b0;
    w_cnt_load   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
        w_cnt_load  = 1'b1;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_EXEC;
        end else if (w_timeout) begin
          w_set_fault = 1'b1;
          w_state_nxt = S_HALTED;
        end
      end
      S_EXEC: begin
        if (i_halt_now) begin
          w_state_nxt = S_HALTED;
        end else if (i_halt) begin
          w_state_nxt = S_HALTED;
          w_pc_nxt    = w_pc_plus4;
          w_retire    = 1'b1;
        end else if (i_pc_stall) begin
          w_state_nxt = S_EXEC;
        end else if (i_redirect_en) begin
          if (|i_redirect_pc[1:0]) begin
            w_set_fault = 1'b1;
            w_state_nxt = S_HALTED;
          end else begin
            w_pc_nxt    = i_redirect_pc;
            w_state_nxt = S_FETCH;
            w_cnt_load  = 1'b1;
            w_retire    = 1'b1;
          end
        end else begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = S_FETCH;
          w_cnt_load  = 1'b1;
          w_retire    = 1'b1;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= NOP;
      r_fault    <= 1'b0;
      r_wait_cnt <= CNT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_load_instr) r_instr <= i_imem_rdata;
      if (w_set_fault)  r_fault <= 1'b1;
      // down-counter of ack wait cycles; terminal count at zero
      if (w_cnt_load)
        r_wait_cnt <= CNT_LOAD;
      else if (r_state == S_FETCH && !i_imem_ack && r_wait_cnt != '0)
        r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [31:0] r_retired_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_retired_count <= '0;
    else if (w_retire)
      r_retired_count <= r_retired_count + 32'd1;
  end

  assign o_retired_count = r_retired_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instruction = r_instr;
  assign o_instr_valid = (r_state == S_EXEC);
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_halted      = (r_state == S_HALTED);
  assign o_fault       = r_fault;

endmodule
